// File: rtl/sensor_hub_decoder.sv
// Command decoder for a bank of DHT11-style sensors: one read at a time,
// checksum validation, and an optional periodic monitor on one channel.
module sensor_hub_decoder #(
  parameter int NUM_SENSORS    = 4,
  parameter int ADDR_W         = 5,
  parameter int MONITOR_PERIOD = 100000000,
  parameter int TIMEOUT_CYCLES = 5000000
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [ADDR_W-1:0]         device_address,
  input  logic [7:0]                request,
  output logic [7:0]                response,
  output logic [7:0]                response_code,
  output logic                      finished,
  output logic                      busy,
  output logic                      monitoring,
  output logic [NUM_SENSORS-1:0]    sensor_start,
  input  logic [NUM_SENSORS-1:0]    sensor_done,
  input  logic [NUM_SENSORS-1:0]    sensor_error,
  input  logic [40*NUM_SENSORS-1:0] sensor_data,
  output logic [1:0]                dbg_state_o
);

  localparam int MON_W = $clog2(MONITOR_PERIOD + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_RESPOND, S_MON_WAIT} state_e;

  state_e            state_q, state_d;
  logic [7:0]        req_q, response_q, resp_d, code_q, code_d;
  logic [ADDR_W-1:0] ch_q, mon_ch_q, mon_ch_d;
  logic              addr_bad_q, sample_q, fin_q, fin_d;
  logic              res_err_q, res_bad_q, res_to_q;
  logic [7:0]        res_temp_q, res_hum_q;
  logic              mon_q, mon_d, mon_hum_q, mon_hum_d, mon_clr, pend_q;
  logic [MON_W-1:0]  mon_cnt_q;
  logic [TO_W-1:0]   timer_q;

  logic [39:0]            frame;
  logic                   done_sel, err_sel;
  logic [NUM_SENSORS-1:0] start_vec;
  logic [7:0]             cks_sum, fail_byte;
  logic                   cks_bad, read_ok, timeout, expiry, idle, accept;
  logic                   addr_bad, is_read, start_sample;

  always_comb begin
    frame     = '0;
    done_sel  = 1'b0;
    err_sel   = 1'b0;
    start_vec = '0;
    for (int i = 0; i < NUM_SENSORS; i++) begin
      if (ch_q == ADDR_W'(i)) begin
        frame        = sensor_data[40*i +: 40];
        done_sel     = sensor_done[i];
        err_sel      = sensor_error[i];
        start_vec[i] = 1'b1;
      end
    end
  end

  assign cks_sum   = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
  assign cks_bad   = (cks_sum != frame[7:0]);
  assign read_ok   = !res_err_q && !res_bad_q && !res_to_q;
  assign fail_byte = {5'b11100, res_err_q, res_bad_q, res_to_q};
  assign timeout   = (timer_q == TO_W'(TIMEOUT_CYCLES - 1));
  assign expiry    = mon_q && (mon_cnt_q == MON_W'(MONITOR_PERIOD - 1));
  assign idle      = (state_q == S_IDLE) || (state_q == S_MON_WAIT);
  assign accept    = idle && enable;
  assign addr_bad  = int'(device_address) >= NUM_SENSORS;
  assign is_read   = (request <= 8'h04);
  // A client request in the same cycle wins; the sample remains pending.
  assign start_sample = idle && !enable && (pend_q || expiry);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_MON_WAIT: begin
        if (accept)            state_d = (addr_bad || !is_read) ? S_RESPOND : S_READ;
        else if (start_sample) state_d = S_READ;
        else                   state_d = mon_q ? S_MON_WAIT : S_IDLE;
      end
      S_READ:    if (done_sel || timeout) state_d = S_RESPOND;
      S_RESPOND: state_d = mon_d ? S_MON_WAIT : S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    resp_d    = response_q;
    code_d    = code_q;
    fin_d     = 1'b0;
    mon_d     = mon_q;
    mon_hum_d = mon_hum_q;
    mon_ch_d  = mon_ch_q;
    mon_clr   = 1'b0;
    if (state_q == S_RESPOND) begin
      fin_d = 1'b1;
      if (sample_q) begin
        code_d = read_ok ? (mon_hum_q ? 8'h14 : 8'h13) : 8'hEE;
        resp_d = read_ok ? (mon_hum_q ? res_hum_q : res_temp_q) : fail_byte;
      end else if (addr_bad_q) begin
        code_d = 8'hED;
        resp_d = 8'hED;
      end else begin
        case (req_q)
          8'h00: begin
            code_d = 8'h10;
            resp_d = read_ok ? 8'h11 : 8'h12;
          end
          8'h01: begin
            code_d = read_ok ? 8'h13 : 8'hEE;
            resp_d = read_ok ? res_temp_q : fail_byte;
          end
          8'h02: begin
            code_d = read_ok ? 8'h14 : 8'hEE;
            resp_d = read_ok ? res_hum_q : fail_byte;
          end
          8'h03, 8'h04: begin
            code_d = read_ok ? ((req_q == 8'h04) ? 8'h16 : 8'h15) : 8'hEE;
            resp_d = read_ok ? 8'hCA : fail_byte;
            if (read_ok) begin
              mon_d     = 1'b1;
              mon_hum_d = (req_q == 8'h04);
              mon_ch_d  = ch_q;
              mon_clr   = 1'b1;
            end
          end
          8'h05, 8'h06: begin
            code_d = (req_q == 8'h06) ? 8'h18 : 8'h17;
            resp_d = 8'hEA;
            if (mon_q && (mon_hum_q == (req_q == 8'h06))) begin
              resp_d  = 8'hCA;
              mon_d   = 1'b0;
              mon_clr = 1'b1;
            end
          end
          default: begin
            code_d = 8'hEC;
            resp_d = 8'hEC;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      req_q      <= '0;
      ch_q       <= '0;
      addr_bad_q <= 1'b0;
      sample_q   <= 1'b0;
      response_q <= '0;
      code_q     <= '0;
      fin_q      <= 1'b0;
      timer_q    <= '0;
      res_err_q  <= 1'b0;
      res_bad_q  <= 1'b0;
      res_to_q   <= 1'b0;
      res_temp_q <= '0;
      res_hum_q  <= '0;
      mon_q      <= 1'b0;
      mon_hum_q  <= 1'b0;
      mon_ch_q   <= '0;
      mon_cnt_q  <= '0;
      pend_q     <= 1'b0;
    end else begin
      response_q <= resp_d;
      code_q     <= code_d;
      fin_q      <= fin_d;
      mon_q      <= mon_d;
      mon_hum_q  <= mon_hum_d;
      mon_ch_q   <= mon_ch_d;
      timer_q    <= (state_q == S_READ) ? timer_q + 1'b1 : '0;
      if (accept) begin
        req_q      <= request;
        ch_q       <= device_address;
        addr_bad_q <= addr_bad;
        sample_q   <= 1'b0;
      end else if (start_sample) begin
        ch_q     <= mon_ch_q;
        sample_q <= 1'b1;
      end
      // Result is frozen on the done/timeout edge; later done pulses are ignored.
      if (state_q == S_READ && (done_sel || timeout)) begin
        res_err_q  <= done_sel && err_sel;
        res_bad_q  <= done_sel && cks_bad;
        res_to_q   <= !done_sel;
        res_temp_q <= frame[23:16];
        res_hum_q  <= frame[39:32];
      end
      if (mon_clr || !mon_q || expiry) mon_cnt_q <= '0;
      else                             mon_cnt_q <= mon_cnt_q + 1'b1;
      if (mon_clr || start_sample) pend_q <= 1'b0;
      else if (expiry)             pend_q <= 1'b1;
    end
  end

  assign response      = response_q;
  assign response_code = code_q;
  assign finished      = fin_q;
  assign busy          = (state_q == S_READ) || (state_q == S_RESPOND);
  assign monitoring    = mon_q;
  assign sensor_start  = (state_q == S_READ) ? start_vec : '0;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_sensor_hub_decoder.sv
// Bench for sensor_hub_decoder: directed scenarios plus randomized requests,
// each response checked against a rule-level model through a scoreboard.
module tb_sensor_hub_decoder;

  localparam int NS = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic [4:0]    device_address = '0;
  logic [7:0]    request = '0;
  logic [7:0]    response, response_code;
  logic          finished, busy, monitoring;
  logic [NS-1:0] sensor_start;
  logic [NS-1:0] sensor_done = '0;
  logic [NS-1:0] sensor_error;
  logic [40*NS-1:0] sensor_data;
  logic [1:0]    dbg_state;

  // Per-channel sensor behaviour: frame contents, error flag, done delay (0 = never).
  logic [39:0] frame [NS];
  logic        err_b [NS];
  int          dly [NS];
  int          hi_cnt [NS];
  int          last_len [NS];

  logic [15:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_fin_cyc = 0;
  int prev_fin_cyc = 0;
  logic prev_fin = 1'b0;

  for (genvar g = 0; g < NS; g++) begin : g_ch
    assign sensor_data[40*g +: 40] = frame[g];
    assign sensor_error[g]         = err_b[g];
  end

  sensor_hub_decoder #(
    .NUM_SENSORS(NS), .ADDR_W(5), .MONITOR_PERIOD(16), .TIMEOUT_CYCLES(32)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .device_address(device_address), .request(request),
    .response(response), .response_code(response_code),
    .finished(finished), .busy(busy), .monitoring(monitoring),
    .sensor_start(sensor_start), .sensor_done(sensor_done),
    .sensor_error(sensor_error), .sensor_data(sensor_data),
    .dbg_state_o(dbg_state)
  );

  // Clock and cycle counter
  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: expected {code,response} for a request, from the command rules.
  function automatic logic [15:0] model_req(input logic [7:0] cmd, input int addr,
                                             input logic [39:0] f, input bit err, input bit to,
                                             input bit arm_t, input bit arm_h);
    int s;
    bit bad, ok;
    logic [7:0] fail;
    if (addr >= NS) return 16'hEDED;
    s    = (int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8])) % 256;
    bad  = !to && (s != int'(f[7:0]));
    ok   = !to && !err && !bad;
    fail = 8'hE0 | {5'b0, err && !to, bad, to};
    case (cmd)
      8'h00:   return ok ? 16'h1011 : 16'h1012;
      8'h01:   return ok ? {8'h13, f[23:16]} : {8'hEE, fail};
      8'h02:   return ok ? {8'h14, f[39:32]} : {8'hEE, fail};
      8'h03:   return ok ? 16'h15CA : {8'hEE, fail};
      8'h04:   return ok ? 16'h16CA : {8'hEE, fail};
      8'h05:   return arm_t ? 16'h17CA : 16'h17EA;
      8'h06:   return arm_h ? 16'h18CA : 16'h18EA;
      default: return 16'hECEC;
    endcase
  endfunction

  // Sensor responder: done pulses once the start has been held dly cycles.
  always @(negedge clock) begin
    for (int i = 0; i < NS; i++) begin
      if (sensor_start[i]) begin
        hi_cnt[i]++;
        sensor_done[i] = (dly[i] > 0) && (hi_cnt[i] == dly[i]);
      end else begin
        if (hi_cnt[i] != 0) last_len[i] = hi_cnt[i];
        hi_cnt[i]      = 0;
        sensor_done[i] = 1'b0;
      end
    end
  end

  // Scoreboard: every finished pulse consumes one expected response.
  always @(negedge clock) begin
    logic [15:0] e;
    if (!reset && finished) begin
      check("fin_width", {31'b0, prev_fin}, 0);
      if (exp_q.size() == 0) begin
        check("unexp_fin", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check("code", {24'b0, response_code}, {24'b0, e[15:8]});
        check("resp", {24'b0, response}, {24'b0, e[7:0]});
      end
      prev_fin_cyc = last_fin_cyc;
      last_fin_cyc = cyc;
    end
    prev_fin = finished;
  end

  task automatic send(input logic [7:0] cmd, input int addr);
    int n = 0;
    int k;
    logic [NS-1:0] exp_start;
    while (busy && n < 200) begin
      @(negedge clock);
      n++;
    end
    exp_start = (cmd <= 8'h04 && addr < NS) ? NS'(1 << addr) : '0;
    request        = cmd;
    device_address = 5'(addr);
    enable         = 1'b1;
    @(negedge clock);
    enable = 1'b0;
    k = 1;
    check("start_vec", {28'b0, sensor_start}, {28'b0, exp_start});
    while (!finished && k < 200) begin
      @(negedge clock);
      k++;
    end
    check("fin_seen", {31'b0, finished}, 1);
    if (cmd > 8'h04 || addr >= NS) check("fin_latency", k, 2);
  endtask

  task automatic wait_drain(input int max);
    int n = 0;
    while (exp_q.size() != 0 && n < max) begin
      @(negedge clock);
      n++;
    end
    check("drain", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_resp"}, {24'b0, response}, 0);
    check({tag, "_code"}, {24'b0, response_code}, 0);
    check({tag, "_fin"}, {31'b0, finished}, 0);
    check({tag, "_busy"}, {31'b0, busy}, 0);
    check({tag, "_mon"}, {31'b0, monitoring}, 0);
    check({tag, "_start"}, {28'b0, sensor_start}, 0);
  endtask

  initial begin
    int cnt;
    for (int i = 0; i < NS; i++) begin
      frame[i] = '0; err_b[i] = 1'b0; dly[i] = 4; hi_cnt[i] = 0; last_len[i] = 0;
    end
    repeat (3) @(negedge clock);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clock);

    // Temperature read on channel 2
    frame[2] = 40'h2A00190043; dly[2] = 5;
    exp_q.push_back(model_req(8'h01, 2, frame[2], 0, 0, 0, 0));
    send(8'h01, 2);
    // Status read with a bad checksum
    frame[1] = 40'h2A00190044; dly[1] = 3;
    exp_q.push_back(model_req(8'h00, 1, frame[1], 0, 0, 0, 0));
    send(8'h00, 1);
    // Humidity read that never completes
    frame[3] = 40'h1122334455; dly[3] = 0;
    exp_q.push_back(model_req(8'h02, 3, frame[3], 0, 1, 0, 0));
    send(8'h02, 3);
    @(negedge clock);
    check("timeout_len", last_len[3], 32);

    // Temperature monitor on channel 0, two samples, then stop
    frame[0] = 40'h3C05170A62; dly[0] = 4;
    exp_q.push_back(model_req(8'h03, 0, frame[0], 0, 0, 0, 0));
    send(8'h03, 0);
    check("mon_armed", {31'b0, monitoring}, 1);
    exp_q.push_back(model_req(8'h01, 0, frame[0], 0, 0, 0, 0));
    exp_q.push_back(model_req(8'h01, 0, frame[0], 0, 0, 0, 0));
    wait_drain(100);
    check("sample_period", last_fin_cyc - prev_fin_cyc, 16);
    exp_q.push_back(model_req(8'h05, 0, frame[0], 0, 0, 1, 0));
    send(8'h05, 0);
    check("mon_off", {31'b0, monitoring}, 0);
    repeat (40) @(negedge clock);

    // Non-read commands and an out-of-range address
    exp_q.push_back(model_req(8'h06, 0, frame[0], 0, 0, 0, 0));
    send(8'h06, 0);
    exp_q.push_back(model_req(8'h09, 0, frame[0], 0, 0, 0, 0));
    send(8'h09, 0);
    exp_q.push_back(model_req(8'h01, 7, frame[0], 0, 0, 0, 0));
    send(8'h01, 7);
    wait_drain(10);

    // Humidity monitor on channel 1; client read spans two expiries
    frame[1] = 40'h370015004C; dly[1] = 3; dly[2] = 0;
    exp_q.push_back(model_req(8'h04, 1, frame[1], 0, 0, 0, 0));
    send(8'h04, 1);
    exp_q.push_back(model_req(8'h01, 2, frame[2], 0, 1, 0, 1));
    exp_q.push_back(model_req(8'h02, 1, frame[1], 0, 0, 0, 1));
    send(8'h01, 2);
    wait_drain(60);
    cnt = 0;
    repeat (6) begin
      @(negedge clock);
      if (sensor_start[1]) cnt++;
    end
    check("no_accum", cnt, 0);
    dly[1] = 0;
    cnt = 0;
    while (!sensor_start[1] && cnt < 40) begin
      @(negedge clock);
      cnt++;
    end
    check("sample_restart", {31'b0, sensor_start[1]}, 1);
    repeat (3) @(negedge clock);
    #2 reset = 1'b1;
    #1 check_all_zero("midreset");
    check("q_at_reset", exp_q.size(), 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    check("mon_after_reset", {31'b0, monitoring}, 0);

    // Randomized requests with the monitor disarmed
    for (int t = 0; t < 40; t++) begin
      logic [7:0]  cmd;
      logic [31:0] hi;
      logic [7:0]  lo;
      logic [39:0] f;
      int a, sel;
      bit e, to;
      sel = $urandom_range(0, 5);
      case (sel)
        0, 1, 2: cmd = 8'(sel);
        3:       cmd = 8'h05;
        4:       cmd = 8'h06;
        default: cmd = 8'($urandom_range(7, 255));
      endcase
      a  = $urandom_range(0, 5);
      hi = $urandom();
      lo = 8'($urandom());
      f  = {hi, lo};
      if ($urandom_range(0, 1) == 1) f[7:0] = f[39:32] + f[31:24] + f[23:16] + f[15:8];
      e  = ($urandom_range(0, 5) == 0);
      to = ($urandom_range(0, 7) == 0);
      if (a < NS) begin
        frame[a] = f; err_b[a] = e;
        dly[a] = to ? 0 : $urandom_range(1, 9);
      end
      exp_q.push_back(model_req(cmd, a, f, e, to && cmd <= 8'h04, 0, 0));
      send(cmd, a);
      if (a < NS) err_b[a] = 1'b0;
    end
    wait_drain(10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sensor_hub_decoder.md
Name: sensor_hub_decoder

Overview:
Multi-channel successor of the single-DHT11 request decoder. Accepts 8-bit client commands addressed to one of NUM_SENSORS 40-bit-frame sensors (DHT11 format), drives that channel's start/done handshake, and validates the checksum. It returns response/response_code pairs and supports periodic monitoring of one channel with a read timeout. Sits between the command UART front-end and the per-channel sensor drivers.

Parameters:
NUM_SENSORS, 4, number of sensor channels (1..32)
ADDR_W, 5, width of device_address
MONITOR_PERIOD, 100000000, clock cycles between monitoring samples
TIMEOUT_CYCLES, 5000000, max cycles from sensor_start to sensor_done before a read is declared failed

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  1-cycle request strobe; accepted only when busy=0
device_address  in  ADDR_W  binary channel index, sampled with enable
request  in  8  command code, sampled with enable
response  out  8  data/status byte
response_code  out  8  class of response
finished  out  1  1-cycle pulse when response/response_code are updated
busy  out  1  high while a read is in progress
monitoring  out  1  high while a monitor is armed
sensor_start  out  NUM_SENSORS  per-channel one-hot read start, held until sensor_done or timeout
sensor_done  in  NUM_SENSORS  per-channel frame complete (level or pulse)
sensor_error  in  NUM_SENSORS  per-channel driver error, valid with sensor_done
sensor_data  in  40*NUM_SENSORS  channel i at [40*i+39:40*i]; {hum_int,hum_float,temp_int,temp_float,checksum}

Behaviour:
- Reset: response=0, response_code=0, finished=0, busy=0, monitoring=0, sensor_start=0, monitor counter=0, state IDLE.
- Checksum valid iff (hum_int+hum_float+temp_int+temp_float) mod 256 == checksum. All four fields are summed.
- read_ok = sensor_done & ~sensor_error & checksum valid, evaluated in the done cycle. Failure = error, bad checksum or timeout.
- States: IDLE, READ, RESPOND, MON_WAIT. READ asserts sensor_start[ch] and counts timeout. RESPOND writes outputs and pulses finished for exactly 1 cycle.
- Accepting a request latches request and address and sets busy the next cycle.
- address >= NUM_SENSORS: no sensor_start; response_code=0xED, response=0xED, finished 2 cycles after enable.
- Commands needing a read (0x00-0x04) go to READ, then:
  - 0x00: code 0x10; response 0x11 if read_ok, else 0x12.
  - 0x01: code 0x13, response temp_int.
  - 0x02: code 0x14, response hum_int.
  - 0x03/0x04: code 0x15/0x16, response 0xCA. Arms the monitor (channel, TEMP/HUM), sets monitoring=1 and clears the counter. Replaces any existing monitor.
  - On failure, 0x01-0x04 instead give code 0xEE, response 0xE0|{sensor_error,checksum_bad,timeout} (bits 2:0). A failed 0x03/0x04 does not arm the monitor.
- Commands without a read:
  - 0x05/0x06 when the matching measure is armed: code 0x17/0x18, response 0xCA, monitoring=0.
  - 0x05/0x06 otherwise: code 0x17/0x18, response 0xEA.
  - Any other code: code 0xEC, response 0xEC.
  - Finished is pulsed 2 cycles after enable.
- Monitoring: the counter increments every cycle while monitoring=1, including during client reads.
  - When the counter reaches MONITOR_PERIOD-1 and the FSM is IDLE, a sample read of the armed channel starts and the counter resets to 0.
  - If the FSM is busy at expiry, the sample is pending and starts on the first IDLE cycle. At most 1 sample is pending; no accumulation.
  - Sample result: code 0x13/0x14 with data, or 0xEE on failure. Each sample pulses finished.
- Simultaneous enable and sample start in IDLE: the client request wins and the sample stays pending. busy=1 during a sample, so enable is ignored.
- enable while busy=1 is dropped with no response.
- sensor_start is deasserted the cycle after done/timeout. A late sensor_done from a timed-out channel is ignored.
- Reset mid-read: all outputs return to reset values immediately (async), the monitor is disarmed and nothing is pending.

Test Plan:
Bench overrides: MONITOR_PERIOD=16, TIMEOUT_CYCLES=32, NUM_SENSORS=4.
- Request 0x01, address 2; ch2 data 0x2A00190043, done after 5 cycles -> sensor_start=0100; finished pulse; code 0x13, response 0x19.
- Request 0x00, address 1; data 0x2A00190044 (bad checksum) -> code 0x10, response 0x12.
- Request 0x02, address 3; sensor_done never asserted -> sensor_start[3] drops after 32 cycles; code 0xEE, response 0xE1.
- Request 0x03, address 0; valid reads each with 4-cycle done -> code 0x15/0xCA; temp samples (code 0x13) every ~16+ cycles. Then send 0x05 -> code 0x17, response 0xCA, monitoring=0, no further finished pulses.
- Request 0x06 with no monitor armed -> code 0x18, response 0xEA. Request 0x09 -> code 0xEC, response 0xEC. Address 7 with 0x01 -> code 0xED, no sensor_start.
- Monitor armed; issue a 0x01 read spanning the period expiry -> client response first, then exactly one sample; assert reset mid-sample -> all outputs 0 and sensor_start=0 immediately.
